id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  Decode-to-execute pipeline register that directly consumes the register file's read outputs.
//  Latches operands, immediate, PC and control fields for the EX stage.
//  Bypasses same-cycle write-back data around the register file.
//  Detects load-use hazards, inserts a one-cycle bubble, and honours branch flushes.
//  Keeps a saturating stall counter for performance checks.
// PARAMETERS
//  XLEN        64  datapath width (operands, imm, pc)
//  CTRL_W      8   control bundle width: [0]memread [1]memwrite [2]regwrite [3]alusrc [4]memtoreg [5]branch [7:6]aluop
//  STALL_CNT_W 32  stall counter width
// PORTS
//  clk          in   1       rising-edge clock; the only clock
//  reset        in   1       asynchronous, active-high reset
//  id_valid     in   1       ID holds a real instruction
//  id_rs1       in   5       source reg 1 index (same value driven to reg file rs1)
//  id_rs2       in   5       source reg 2 index
//  id_rd        in   5       destination reg index
//  id_readdata1 in   XLEN    reg file readdata1
//  id_readdata2 in   XLEN    reg file readdata2
//  id_imm       in   XLEN    sign-extended immediate
//  id_pc        in   XLEN    instruction PC
//  id_ctrl      in   CTRL_W  decoded control bundle
//  wb_writereg  in   1       WB stage writes a register this cycle
//  wb_rd        in   5       WB destination index
//  wb_writedata in   XLEN    WB write data
//  flush        in   1       branch taken in EX: kill the ID instruction
//  stall        out  1       combinational: hold PC and IF/ID this cycle
//  ex_valid     out  1       EX holds a real instruction
//  ex_rs1/rs2/rd out 5 each  latched register indices
//  ex_data1     out  XLEN    latched operand 1
//  ex_data2     out  XLEN    latched operand 2
//  ex_imm       out  XLEN    latched immediate
//  ex_pc        out  XLEN    latched PC
//  ex_ctrl      out  CTRL_W  latched control; all-zero for any bubble
//  stall_count  out  STALL_CNT_W  number of stall cycles, saturating
// BEHAVIOUR
//  Reset (async, any time, including mid-stall): all ex_* and stall_count go to 0 immediately.
//    stall therefore reads 0.
//  hazard = id_valid & ex_valid & ex_ctrl[0] & (ex_rd!=0) & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
//  stall  = hazard & ~flush. Combinational, no latency.
//  Bypass (combinational, before latching):
//    op1 = (wb_writereg & wb_rd!=0 & wb_rd==id_rs1) ? wb_writedata : id_readdata1.
//    op2 uses the same rule with id_rs2 / id_readdata2.
//  Posedge update, priority reset > flush > stall > load:
//    flush : bubble. ex_valid=0; all ex_* fields=0. stall_count unchanged.
//    stall : bubble, with the same values as flush. stall_count += 1, saturating at all-ones.
//    load  : ex_valid=id_valid; ex_ctrl = id_valid ? id_ctrl : 0.
//            ex_data1=op1, ex_data2=op2; remaining fields copied from id_*.
//  A bubble always lasts exactly one cycle: the next cycle ex_valid=0, so hazard=0.
//    The held ID instruction then loads.
//  x0 is never a hazard source and is never bypassed; rd==0 loads do not stall.
//  Simultaneous flush and hazard: flush wins; stall=0; counter not incremented.
//  All arithmetic is unsigned; the counter never wraps.
// TESTING
//  1. Load x5 in EX (ctrl[0]=1, rd=5, valid); ID add rs1=5 valid.
//     -> stall=1; after edge ex_valid=0, ex_ctrl=0, stall_count=1.
//     -> Next edge: add latched, stall=0.
//  2. wb_writereg=1, wb_rd=7, wb_writedata=0xDEADBEEF; id_rs2=7, id_readdata2=0.
//     -> ex_data2=0xDEADBEEF after edge. Repeat with wb_rd=0: ex_data2=0.
//  3. Load with rd=0 in EX; ID rs1=0 -> stall=0; instruction latches normally.
//  4. Hazard active and flush=1 in the same cycle -> stall=0, bubble latched, stall_count unchanged.
//  5. STALL_CNT_W=4; force 20 stall cycles -> stall_count=15 and holds.
//  6. Assert reset between clock edges while ex_valid=1 and stall_count=3.
//     -> All outputs 0 before the next edge; normal loading resumes after release.

Source files
------------

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass, load-use stall and flush
module id_ex_stage #(
    parameter int XLEN        = 64,
    parameter int CTRL_W      = 8,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1,
    input  logic [4:0]             id_rs2,
    input  logic [4:0]             id_rd,
    input  logic [XLEN-1:0]        id_readdata1,
    input  logic [XLEN-1:0]        id_readdata2,
    input  logic [XLEN-1:0]        id_imm,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [CTRL_W-1:0]      id_ctrl,
    input  logic                   wb_writereg,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_writedata,
    input  logic                   flush,
    output logic                   stall,
    output logic                   ex_valid,
    output logic [4:0]             ex_rs1,
    output logic [4:0]             ex_rs2,
    output logic [4:0]             ex_rd,
    output logic [XLEN-1:0]        ex_data1,
    output logic [XLEN-1:0]        ex_data2,
    output logic [XLEN-1:0]        ex_imm,
    output logic [XLEN-1:0]        ex_pc,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic [STALL_CNT_W-1:0] stall_count
);

    logic            hazard;
    logic            bypass1;
    logic            bypass2;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;

    // Load-use detection against the instruction now in EX; x0 never creates a dependency
    always_comb begin
        hazard = id_valid & ex_valid & ex_ctrl[0] & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        stall  = hazard & ~flush;
    end

    // Write-back data bypass around the register file, same-cycle write wins over stale read
    always_comb begin
        bypass1 = wb_writereg & (wb_rd != 5'd0) & (wb_rd == id_rs1);
        bypass2 = wb_writereg & (wb_rd != 5'd0) & (wb_rd == id_rs2);
        op1     = bypass1 ? wb_writedata : id_readdata1;
        op2     = bypass2 ? wb_writedata : id_readdata2;
    end

    // Pipeline register: flush and stall both insert an all-zero bubble, otherwise load from ID
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            ex_ctrl  <= '0;
        end else if (flush || stall) begin
            ex_valid <= 1'b0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            ex_rd    <= '0;
            ex_data1 <= '0;
            ex_data2 <= '0;
            ex_imm   <= '0;
            ex_pc    <= '0;
            ex_ctrl  <= '0;
        end else begin
            ex_valid <= id_valid;
            ex_rs1   <= id_rs1;
            ex_rs2   <= id_rs2;
            ex_rd    <= id_rd;
            ex_data1 <= op1;
            ex_data2 <= op2;
            ex_imm   <= id_imm;
            ex_pc    <= id_pc;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
        end
    end

    // Saturating count of stall cycles; a flushed hazard is not a stall and is not counted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {STALL_CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              id_valid;
    logic [4:0]        id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0]   id_readdata1, id_readdata2, id_imm, id_pc;
    logic [CTRL_W-1:0] id_ctrl;
    logic              wb_writereg;
    logic [4:0]        wb_rd;
    logic [XLEN-1:0]   wb_writedata;
    logic              flush;
    logic              stall;
    logic              ex_valid;
    logic [4:0]        ex_rs1, ex_rs2, ex_rd;
    logic [XLEN-1:0]   ex_data1, ex_data2, ex_imm, ex_pc;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_count;

    int total = 0;
    int bad   = 0;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .STALL_CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_readdata1(id_readdata1), .id_readdata2(id_readdata2),
        .id_imm(id_imm), .id_pc(id_pc), .id_ctrl(id_ctrl),
        .wb_writereg(wb_writereg), .wb_rd(wb_rd), .wb_writedata(wb_writedata),
        .flush(flush), .stall(stall), .ex_valid(ex_valid),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_ctrl(ex_ctrl), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                          input logic [4:0] rd, input logic [7:0] ctrl,
                          input logic [63:0] d1, input logic [63:0] d2,
                          input logic [63:0] imm, input logic [63:0] pc);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd; id_ctrl = ctrl;
        id_readdata1 = d1; id_readdata2 = d2; id_imm = imm; id_pc = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0;
        wb_writereg = 1'b0; wb_rd = '0; wb_writedata = '0;
        set_id(1'b0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
        step();
        check("rst_ex_valid", ex_valid, 0);
        check("rst_ex_ctrl", ex_ctrl, 0);
        check("rst_ex_data1", ex_data1, 0);
        check("rst_count", stall_count, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;

        // load-use: lw x5 then add using x5
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 8'h15, 64'h11, 64'h22, 64'h8, 64'h3C);
        #1 check("t1_no_stall_empty_ex", stall, 0);
        step();
        check("t1_load_valid", ex_valid, 1);
        check("t1_load_ctrl", ex_ctrl, 8'h15);
        check("t1_load_rd", ex_rd, 5);
        check("t1_load_data1", ex_data1, 64'h11);
        set_id(1'b1, 5'd5, 5'd3, 5'd6, 8'h84, 64'h100, 64'h200, 64'h7, 64'h40);
        #1 check("t1_stall", stall, 1);
        step();
        check("t1_bubble_valid", ex_valid, 0);
        check("t1_bubble_ctrl", ex_ctrl, 0);
        check("t1_bubble_pc", ex_pc, 0);
        check("t1_count1", stall_count, 1);
        check("t1_stall_released", stall, 0);
        step();
        check("t1_add_valid", ex_valid, 1);
        check("t1_add_rd", ex_rd, 6);
        check("t1_add_ctrl", ex_ctrl, 8'h84);
        check("t1_add_data1", ex_data1, 64'h100);
        check("t1_add_pc", ex_pc, 64'h40);
        check("t1_add_imm", ex_imm, 64'h7);

        // write-back bypass
        set_id(1'b1, 5'd8, 5'd7, 5'd9, 8'h04, 64'h55, 64'h0, 64'h0, 64'h44);
        wb_writereg = 1'b1; wb_rd = 5'd7; wb_writedata = 64'hDEADBEEF;
        #1 check("t2_no_stall", stall, 0);
        step();
        check("t2_bypass_data2", ex_data2, 64'hDEADBEEF);
        check("t2_nobypass_data1", ex_data1, 64'h55);
        wb_rd = 5'd0; id_rs2 = 5'd0;
        step();
        check("t2_x0_not_bypassed", ex_data2, 0);
        wb_rd = 5'd8; id_rs1 = 5'd8; wb_writedata = 64'hCAFE;
        step();
        check("t2_bypass_data1", ex_data1, 64'hCAFE);
        wb_writereg = 1'b0;
        step();
        check("t2_writereg_off", ex_data1, 64'h55);

        // load to x0 never stalls
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 8'h01, 64'h1, 64'h2, 64'h0, 64'h50);
        step();
        set_id(1'b1, 5'd0, 5'd0, 5'd4, 8'h04, 64'h77, 64'h0, 64'h0, 64'h54);
        #1 check("t3_rd0_no_stall", stall, 0);
        step();
        check("t3_valid", ex_valid, 1);
        check("t3_rd", ex_rd, 4);
        check("t3_data1", ex_data1, 64'h77);

        // flush beats hazard
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 8'h01, 64'h1, 64'h2, 64'h0, 64'h58);
        step();
        set_id(1'b1, 5'd5, 5'd0, 5'd6, 8'h04, 64'h9, 64'h0, 64'h0, 64'h5C);
        flush = 1'b1;
        #1 check("t4_flush_no_stall", stall, 0);
        step();
        flush = 1'b0;
        check("t4_bubble_valid", ex_valid, 0);
        check("t4_bubble_ctrl", ex_ctrl, 0);
        check("t4_count_held", stall_count, 1);

        // drive count to 3 with a self-dependent load, then reset mid-stall
        set_id(1'b1, 5'd5, 5'd0, 5'd5, 8'h01, 64'hA, 64'h0, 64'h0, 64'h60);
        step(); step(); step(); step(); step();
        check("t6_pre_valid", ex_valid, 1);
        check("t6_pre_count", stall_count, 3);
        check("t6_pre_stall", stall, 1);
        #2 reset = 1'b1;
        #1 check("t6_async_valid", ex_valid, 0);
        check("t6_async_count", stall_count, 0);
        check("t6_async_ctrl", ex_ctrl, 0);
        check("t6_async_pc", ex_pc, 0);
        check("t6_async_stall", stall, 0);
        #1 reset = 1'b0;
        step();
        check("t6_resume_valid", ex_valid, 1);
        check("t6_resume_pc", ex_pc, 64'h60);
        check("t6_resume_count", stall_count, 0);

        // saturation: one stall every other cycle, 20 stalls in 40 cycles
        for (int i = 0; i < 39; i++) step();
        check("t5_count_sat", stall_count, 15);
        for (int i = 0; i < 6; i++) step();
        check("t5_count_hold", stall_count, 15);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
